// File: rtl/qed_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qed_pkg                                                            |
// | Shared QED types and constants for the dup controller and cache.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package qed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ORIG  = 2'd1,
        ST_DUP   = 2'd2,
        ST_CHECK = 2'd3
    } qed_state_e;

    localparam logic [6:0] QED_NOP_OPCODE        = 7'b1111111;
    localparam int         QED_ICACHESIZE_DEFAULT = 128;

endpackage
`default_nettype wire

// File: rtl/qed_occ_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qed_occ_counter                                                    |
// | Saturating up/down occupancy counter with over/underflow flags.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module qed_occ_counter #(
    parameter int MAX_VAL = 127,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          ovf,
    output logic          unf
);

    localparam logic [CW-1:0] c_max = CW'(MAX_VAL);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next;

    // Flags report the offending event; the count itself never wraps.
    always_comb begin
        w_next = r_count;
        if (inc && (r_count != c_max)) begin
            w_next = r_count + CW'(1);
        end else if (dec && (r_count != '0)) begin
            w_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count      = r_count;
    assign count_next = w_next;
    assign ovf        = inc & (r_count == c_max);
    assign unf        = dec & (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/qed_dup_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qed_dup_ctrl                                                       |
// | QED original/duplicate mode controller with occupancy tracking.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module qed_dup_ctrl
    import qed_pkg::*;
#(
    parameter int ICACHESIZE = QED_ICACHESIZE_DEFAULT,
    parameter int CW         = $clog2(ICACHESIZE) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          dup_req,
    input  logic          IF_stall,
    input  logic          qic_vld,
    output logic          exec_dup,
    output logic          qed_ready,
    output logic [CW-1:0] occupancy,
    output logic          qed_err
);

    localparam logic [CW-1:0] c_full = CW'(ICACHESIZE - 1);

    qed_state_e    r_state;
    qed_state_e    w_state_next;
    logic          r_exec_dup;
    logic          r_ready;
    logic          r_err;
    logic          w_event;
    logic          w_inc;
    logic          w_dec;
    logic          w_ovf;
    logic          w_unf;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_next;

    assign w_event = qic_vld & ~IF_stall;
    assign w_inc   = w_event & ((r_state == ST_ORIG) | (r_state == ST_CHECK));
    assign w_dec   = w_event & (r_state == ST_DUP);

    qed_occ_counter #(
        .MAX_VAL (ICACHESIZE - 1),
        .CW      (CW)
    ) u_occ (
        .clk        (clk),
        .rst        (rst),
        .inc        (w_inc),
        .dec        (w_dec),
        .count      (w_count),
        .count_next (w_cnt_next),
        .ovf        (w_ovf),
        .unf        (w_unf)
    );

    // A stall freezes the mode. Switching to DUP wins over returning to
    // IDLE so that a freshly counted original is never stranded.
    always_comb begin
        w_state_next = r_state;
        if (!IF_stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (ena) w_state_next = ST_ORIG;
                end
                ST_ORIG: begin
                    if ((dup_req || (w_cnt_next == c_full)) && (w_cnt_next != '0)) begin
                        w_state_next = ST_DUP;
                    end else if (!ena && (w_count == '0)) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_DUP: begin
                    if (w_cnt_next == '0) w_state_next = ST_CHECK;
                end
                ST_CHECK: begin
                    w_state_next = ST_ORIG;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_exec_dup <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_exec_dup <= (w_state_next == ST_DUP);
            r_ready    <= (w_state_next == ST_CHECK);
            if (w_ovf || w_unf) r_err <= 1'b1;
        end
    end

    assign exec_dup  = r_exec_dup;
    assign qed_ready = r_ready;
    assign occupancy = w_count;
    assign qed_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qed_dup_ctrl                                                    |
// | Self-checking bench for qed_dup_ctrl with a behavioural model.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_qed_dup_ctrl;

    localparam int c_size = 8;
    localparam int c_cw   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, depth 8
    logic rst = 1'b1, ena = 1'b0, dup_req = 1'b0, IF_stall = 1'b0, qic_vld = 1'b0;
    logic exec_dup, qed_ready, qed_err;
    logic [c_cw-1:0] occupancy;

    // depth-2 instance, where an overflow is reachable
    logic rst2 = 1'b1, ena2 = 1'b0, vld2 = 1'b0;
    logic exec_dup2, qed_ready2, qed_err2;
    logic [1:0] occupancy2;

    // bare counter, to reach the underflow flag
    logic crst = 1'b1, cinc = 1'b0, cdec = 1'b0;
    logic [3:0] ccount, ccount_next;
    logic covf, cunf;

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle, 1 orig, 2 dup, 3 check
    int m_mode = 0;
    int m_occ  = 0;
    bit m_err  = 1'b0;

    qed_dup_ctrl #(.ICACHESIZE(c_size), .CW(c_cw)) dut (
        .clk(clk), .rst(rst), .ena(ena), .dup_req(dup_req), .IF_stall(IF_stall),
        .qic_vld(qic_vld), .exec_dup(exec_dup), .qed_ready(qed_ready),
        .occupancy(occupancy), .qed_err(qed_err)
    );

    qed_dup_ctrl #(.ICACHESIZE(2), .CW(2)) dut2 (
        .clk(clk), .rst(rst2), .ena(ena2), .dup_req(1'b0), .IF_stall(1'b0),
        .qic_vld(vld2), .exec_dup(exec_dup2), .qed_ready(qed_ready2),
        .occupancy(occupancy2), .qed_err(qed_err2)
    );

    qed_occ_counter #(.MAX_VAL(5), .CW(4)) u_cnt (
        .clk(clk), .rst(crst), .inc(cinc), .dec(cdec),
        .count(ccount), .count_next(ccount_next), .ovf(covf), .unf(cunf)
    );

    function automatic void model_step();
        int  nxt;
        bit  ev;
        ev = qic_vld && !IF_stall;
        if (rst) begin
            m_mode = 0; m_occ = 0; m_err = 1'b0;
        end else if (!IF_stall) begin
            case (m_mode)
                0: if (ena) m_mode = 1;
                1, 3: begin
                    nxt = m_occ + (ev ? 1 : 0);
                    if (ev && m_occ == c_size - 1) begin
                        m_err = 1'b1;
                        nxt = c_size - 1;
                    end
                    if (m_mode == 3) m_mode = 1;
                    else if ((dup_req || nxt == c_size - 1) && nxt > 0) m_mode = 2;
                    else if (!ena && m_occ == 0) m_mode = 0;
                    m_occ = nxt;
                end
                default: begin
                    if (ev) begin
                        if (m_occ == 0) m_err = 1'b1;
                        else m_occ = m_occ - 1;
                    end
                    if (m_occ == 0) m_mode = 3;
                end
            endcase
        end
    endfunction

    function automatic logic [6:0] model_vec();
        return {m_mode == 2, m_mode == 3, m_err, 4'(m_occ)};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; crst = 1'b1;
        tick();
        rst = 1'b0; rst2 = 1'b0; crst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({exec_dup, qed_ready, qed_err, occupancy} !== 7'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got %b expected 0000000", i,
                         {exec_dup, qed_ready, qed_err, occupancy});
            end
        end
        ena = 1'b1;
        tick();
        qic_vld = 1'b1;
        tick();
        qic_vld = 1'b0;
        checks++;
        if (occupancy !== 4'd1) begin
            errors++;
            $display("FAIL enter_orig: occupancy got %0d expected 1", occupancy);
        end
        dup_req = 1'b1;
        tick();
        dup_req = 1'b0;
        qic_vld = 1'b1;
        tick();
        qic_vld = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        qic_vld = 1'b1;
        repeat (5) tick();
        qic_vld = 1'b0;
        checks++;
        if (occupancy !== 4'd5 || exec_dup !== 1'b0) begin
            errors++;
            $display("FAIL burst_orig: occ/dup got %0d/%b expected 5/0", occupancy, exec_dup);
        end
        dup_req = 1'b1;
        tick();
        dup_req = 1'b0;
        checks++;
        if (exec_dup !== 1'b1 || occupancy !== 4'd5) begin
            errors++;
            $display("FAIL burst_dup: dup/occ got %b/%0d expected 1/5", exec_dup, occupancy);
        end
        qic_vld = 1'b1;
        repeat (5) tick();
        qic_vld = 1'b0;
        checks++;
        if ({exec_dup, qed_ready, occupancy} !== 6'b01_0000) begin
            errors++;
            $display("FAIL burst_ready: got %b expected 010000", {exec_dup, qed_ready, occupancy});
        end
        tick();
        checks++;
        if ({exec_dup, qed_ready, occupancy} !== 6'b00_0000) begin
            errors++;
            $display("FAIL burst_back_orig: got %b expected 000000", {exec_dup, qed_ready, occupancy});
        end
    endtask

    task automatic test_forced_and_stall();
        qic_vld = 1'b1;
        repeat (7) tick();
        checks++;
        if (exec_dup !== 1'b1 || occupancy !== 4'd7) begin
            errors++;
            $display("FAIL forced_dup: dup/occ got %b/%0d expected 1/7", exec_dup, occupancy);
        end
        IF_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (exec_dup !== 1'b1 || occupancy !== 4'd7) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: dup/occ got %b/%0d expected 1/7", i, exec_dup, occupancy);
            end
        end
        IF_stall = 1'b0;
        tick();
        checks++;
        if (occupancy !== 4'd6) begin
            errors++;
            $display("FAIL stall_resume: occupancy got %0d expected 6", occupancy);
        end
        repeat (6) tick();
        qic_vld = 1'b0;
        checks++;
        if ({exec_dup, qed_ready, occupancy} !== 6'b01_0000) begin
            errors++;
            $display("FAIL forced_ready: got %b expected 010000", {exec_dup, qed_ready, occupancy});
        end
        tick();
    endtask

    task automatic test_rst_mid_dup();
        qic_vld = 1'b1;
        repeat (3) tick();
        qic_vld = 1'b0;
        dup_req = 1'b1;
        tick();
        dup_req = 1'b0;
        checks++;
        if (exec_dup !== 1'b1 || occupancy !== 4'd3) begin
            errors++;
            $display("FAIL pre_rst_dup: dup/occ got %b/%0d expected 1/3", exec_dup, occupancy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({exec_dup, qed_ready, qed_err, occupancy} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_dup: got %b expected 0000000", {exec_dup, qed_ready, qed_err, occupancy});
        end
        qic_vld = 1'b1;
        tick();
        checks++;
        if (occupancy !== 4'd0) begin
            errors++;
            $display("FAIL idle_no_count: occupancy got %0d expected 0", occupancy);
        end
        tick();
        qic_vld = 1'b0;
        checks++;
        if (occupancy !== 4'd1) begin
            errors++;
            $display("FAIL orig_after_idle: occupancy got %0d expected 1", occupancy);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            ena      = ($urandom_range(0, 9) != 0);
            dup_req  = ($urandom_range(0, 9) == 0);
            IF_stall = ($urandom_range(0, 3) == 0);
            qic_vld  = $urandom_range(0, 1) == 1;
            tick();
            exp = model_vec();
            checks++;
            if ({exec_dup, qed_ready, qed_err, occupancy} !== exp) begin
                errors++;
                $display("FAIL random cyc%0d: dup,rdy,err,occ got %b expected %b", i,
                         {exec_dup, qed_ready, qed_err, occupancy}, exp);
            end
        end
        rst = 1'b0; IF_stall = 1'b0; qic_vld = 1'b0; dup_req = 1'b0;
    endtask

    task automatic test_overflow_sticky();
        ena2 = 1'b1;
        tick();
        vld2 = 1'b1;
        tick();
        tick();
        checks++;
        if ({exec_dup2, qed_ready2, occupancy2} !== 4'b0100) begin
            errors++;
            $display("FAIL small_check: got %b expected 0100", {exec_dup2, qed_ready2, occupancy2});
        end
        tick();
        checks++;
        if ({exec_dup2, qed_ready2, qed_err2, occupancy2} !== 5'b00001) begin
            errors++;
            $display("FAIL small_orig: got %b expected 00001", {exec_dup2, qed_ready2, qed_err2, occupancy2});
        end
        tick();
        vld2 = 1'b0;
        checks++;
        if ({exec_dup2, qed_err2, occupancy2} !== 4'b1101) begin
            errors++;
            $display("FAIL overflow_err: dup,err,occ got %b expected 1101", {exec_dup2, qed_err2, occupancy2});
        end
        repeat (3) tick();
        checks++;
        if (qed_err2 !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", qed_err2);
        end
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        checks++;
        if ({exec_dup2, qed_err2, occupancy2} !== 4'b0000) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0000", {exec_dup2, qed_err2, occupancy2});
        end
    endtask

    task automatic test_counter_flags();
        cdec = 1'b1;
        tick();
        checks++;
        if (cunf !== 1'b1 || ccount !== 4'd0) begin
            errors++;
            $display("FAIL underflow: unf/count got %b/%0d expected 1/0", cunf, ccount);
        end
        cdec = 1'b0;
        cinc = 1'b1;
        repeat (5) tick();
        checks++;
        if (covf !== 1'b1 || ccount !== 4'd5) begin
            errors++;
            $display("FAIL overflow_flag: ovf/count got %b/%0d expected 1/5", covf, ccount);
        end
        tick();
        cinc = 1'b0;
        checks++;
        if (ccount !== 4'd5) begin
            errors++;
            $display("FAIL saturate: count got %0d expected 5", ccount);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_burst();
        test_forced_and_stall();
        test_rst_mid_dup();
        test_random();
        test_overflow_sticky();
        test_counter_flags();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qed_dup_ctrl.md
# qed_dup_ctrl

Mode controller for the QED duplicate-execution path. It generates `exec_dup` for the QED instruction cache and tracks the cache's occupancy by counting its valid output. It switches from original to duplicate execution on request, or by force when the queue is full. It signals `qed_ready` on the cycle the originals and duplicates are balanced, which is the point where a consistency check may be taken.

## Interface
- `ICACHESIZE`, default 128: depth of the downstream instruction queue. Usable capacity is ICACHESIZE-1.
- `CW`, default $clog2(ICACHESIZE)+1: occupancy counter width.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `ena` input 1: QED enable. When low, the block idles.
- `dup_req` input 1: request to enter duplicate mode. Driven free or non-deterministically by the formal harness.
- `IF_stall` input 1: fetch stall. Same signal that the cache sees.
- `qic_vld` input 1: valid output of the cache. High when the cache inserts or deletes this cycle.
- `exec_dup` output 1: registered. 1 means duplicate mode.
- `qed_ready` output 1: registered, one-cycle pulse. Originals and duplicates are balanced.
- `occupancy` output CW: registered count of originals not yet duplicated.
- `qed_err` output 1: registered, sticky. Counter over/underflow detected.

## Operation
- States: IDLE, ORIG, DUP, CHECK. Encoding comes from the package.
- `exec_dup` = 1 only in DUP. `qed_ready` = 1 only in CHECK.
- Counting: an event is `qic_vld & ~IF_stall`.
  - In ORIG and CHECK, an event increments `occupancy`.
  - In DUP, an event decrements `occupancy`.
  - In IDLE, nothing is counted.
- Transitions (all evaluated at posedge):
  - IDLE→ORIG: when `ena`=1.
  - ORIG→IDLE: when `ena`=0 and `occupancy`=0.
  - ORIG→DUP: when `~IF_stall` and (`dup_req` or count_next == ICACHESIZE-1) and count_next>0. count_next is the occupancy after this cycle's event.
  - DUP→CHECK: when count_next == 0.
  - CHECK→ORIG: unconditionally, one cycle later.
- DUP ignores `ena` and `dup_req`. It always drains to 0.
- `IF_stall`=1 freezes the state, `exec_dup` and `occupancy`.
- Overflow: an event in ORIG/CHECK with `occupancy` == ICACHESIZE-1 sets `qed_err`. The count saturates.
- Underflow: an event in DUP with `occupancy`=0 sets `qed_err`. The count holds at 0.
- `qed_err` clears only on `rst`.
- Arithmetic is unsigned CW-bit. No wrap is permitted.

## Timing
- Reset values:
  - state IDLE
  - `exec_dup`=0
  - `qed_ready`=0
  - `occupancy`=0
  - `qed_err`=0
- `rst` mid-DUP returns to IDLE next cycle with all outputs at their reset values.
- Mode change latency:
  - A transition decided at edge N is visible on `exec_dup` from cycle N+1.
  - The cache reacts combinationally in cycle N+1.
- `qic_vld` is combinational from the cache and is sampled in the same cycle as `exec_dup`.
- Forced switch: the insert that makes occupancy ICACHESIZE-1 causes DUP on the next cycle. No further original is counted.
- Simultaneous events:
  - When `dup_req` and an event coincide in ORIG, the event is counted first and then DUP is entered.
  - When `dup_req` arrives with count_next=0, it is ignored.
- `qed_ready` is high for exactly one cycle per completed burst. Events in that cycle count as originals.

## Structure
- Package `qed_pkg` holds:
  - the state enum
  - `QED_NOP_OPCODE` = 7'b1111111
  - the default depth constant, shared with the cache.
- One sub-module, `qed_occ_counter`: an up/down saturating counter with overflow/underflow flags. The FSM stays in the top level.

## Test plan
- Reset, then hold `ena`=0 for 10 cycles → state IDLE, all outputs 0. `ena`=1 → ORIG on the next cycle.
- 5 events in ORIG, then `dup_req`=1 → `exec_dup`=1 on the next cycle. 5 events → `occupancy`=0, `qed_ready` pulses 1 cycle, then back in ORIG.
- With ICACHESIZE=8, 7 events and `dup_req`=0 → forced DUP, `occupancy`=7. Drain 7 → `qed_ready` pulse.
- `IF_stall`=1 with `qic_vld`=1 during DUP, 4 cycles → occupancy and `exec_dup` unchanged. Deassert → counting resumes.
- `qic_vld`=1 in DUP at occupancy 0 (injected) → `qed_err`=1 and stays 1 until `rst`.
- `rst` mid-DUP at occupancy 3 → next cycle `exec_dup`=0, `occupancy`=0, state IDLE.
